sa_skew_feeder: RTL and testbench



---
 rtl/sa_pkg.sv | 20 ++
 rtl/sa_lane_delay.sv | 36 +++
 rtl/sa_skew_feeder.sv | 130 +++++++++++++
 tb/tb_sa_skew_feeder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array subsystem: feeder FSM states and
// operand lane slice offsets used by both the skew feeder and the drain side.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } sa_feed_state_e;

  // A lanes occupy the low half of a beat, B lanes the high half.
  function automatic int a_lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int b_lane_lsb(input int lane, input int lanes, input int width);
    return (lanes + lane) * width;
  endfunction

endpackage

// File: rtl/sa_lane_delay.sv
// Enable-gated shift register for one operand lane; DEPTH beats of delay,
// DEPTH=0 degenerates to a wire.
module sa_lane_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    wire unused_ok = &{1'b0, clk, rst, clr, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < DEPTH; j++) sr[j] <= '0;
      end else if (clr) begin
        for (int j = 0; j < DEPTH; j++) sr[j] <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
      end
    end

    // Oldest entry: the value pushed DEPTH writes ago.
    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/sa_skew_feeder.sv
// Skews operand beats diagonally (lane i delayed by i writes) and appends
// N-1 zero flush beats, writing everything into the array input FIFO.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4,
  parameter int BUS_WIDTH = 2 * DIN_WIDTH * N
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           M_minus_one,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BUS_WIDTH-1:0] s_data,
  input  logic                 in_fifo_full,
  output logic                 wr_fifo,
  output logic [BUS_WIDTH-1:0] din,
  output logic                 busy,
  output logic                 done
);

  // Handshake: a beat moves when s_valid && s_ready; a FIFO write happens in
  // every cycle wr_fifo is high, and wr_fifo is never high while in_fifo_full.

  localparam int FW         = (N > 2) ? $clog2(N) : 1;
  localparam int FLUSH_LAST = (N > 1) ? N - 2 : 0;

  sa_feed_state_e state, state_next;

  logic [7:0]    m_last;
  logic [7:0]    beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          start_acc;
  logic          done_set;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    wr_fifo    = 1'b0;
    start_acc  = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        s_ready = !in_fifo_full;
        wr_fifo = s_valid && !in_fifo_full;
        if (wr_fifo && (beat_cnt == m_last)) begin
          if (N > 1) begin
            state_next = FLUSH;
          end else begin
            state_next = IDLE;
            done_set   = 1'b1;
          end
        end
      end
      FLUSH: begin
        wr_fifo = !in_fifo_full;
        if (wr_fifo && (flush_cnt == FW'(FLUSH_LAST))) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      m_last    <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_set;
      if (start_acc) begin
        m_last    <= M_minus_one;
        beat_cnt  <= '0;
        flush_cnt <= '0;
      end else begin
        if (state == STREAM && wr_fifo) beat_cnt  <= beat_cnt + 8'd1;
        if (state == FLUSH  && wr_fifo) flush_cnt <= flush_cnt + FW'(1);
      end
    end
  end

  assign busy = (state != IDLE);

  // Lane inputs are zero outside STREAM, which supplies the flush padding and
  // keeps the lane-0 pass-through quiet in IDLE.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DIN_WIDTH-1:0] a_in, b_in, a_out, b_out;

    assign a_in = (state == STREAM) ? s_data[a_lane_lsb(i, DIN_WIDTH) +: DIN_WIDTH] : '0;
    assign b_in = (state == STREAM) ? s_data[b_lane_lsb(i, N, DIN_WIDTH) +: DIN_WIDTH] : '0;

    sa_lane_delay #(.WIDTH(DIN_WIDTH), .DEPTH(i)) u_a_delay (
      .clk (sys_clk),
      .rst (rst),
      .clr (start_acc),
      .en  (wr_fifo),
      .d   (a_in),
      .q   (a_out)
    );

    sa_lane_delay #(.WIDTH(DIN_WIDTH), .DEPTH(i)) u_b_delay (
      .clk (sys_clk),
      .rst (rst),
      .clr (start_acc),
      .en  (wr_fifo),
      .d   (b_in),
      .q   (b_out)
    );

    assign din[a_lane_lsb(i, DIN_WIDTH) +: DIN_WIDTH]    = a_out;
    assign din[b_lane_lsb(i, N, DIN_WIDTH) +: DIN_WIDTH] = b_out;
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Randomized scoreboard bench for sa_skew_feeder: the driver issues jobs and
// queues the expected skewed beats, a negedge monitor pops and compares.
module tb_sa_skew_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int BW = 2 * DW * N;

  logic          sys_clk;
  logic          rst;
  logic          start;
  logic [7:0]    M_minus_one;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          in_fifo_full;
  logic          wr_fifo;
  logic [BW-1:0] din;
  logic          busy;
  logic          done;

  sa_skew_feeder #(.DIN_WIDTH(DW), .N(N), .BUS_WIDTH(BW)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .start        (start),
    .M_minus_one  (M_minus_one),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .in_fifo_full (in_fifo_full),
    .wr_fifo      (wr_fifo),
    .din          (din),
    .busy         (busy),
    .done         (done)
  );

  // ---------------- clock ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int            len_q[$];
  int            wr_seen;
  bit            exp_done;
  int            n_vec;
  int            n_fail;
  logic [BW-1:0] beats [256];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Output rule: beat k, lane i = input beat k-i when 0 <= k-i < m, else 0.
  function automatic logic [BW-1:0] model_beat(input int k, input int m);
    logic [BW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = k - i;
      if (idx >= 0 && idx < m) begin
        w[i*DW +: DW]     = beats[idx][i*DW +: DW];
        w[(N+i)*DW +: DW] = beats[idx][(N+i)*DW +: DW];
      end
    end
    return w;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (exp_done) begin
        check("done_pulse", {62'd0, done, busy}, 64'd2);
        exp_done = 1'b0;
      end else if (done) begin
        check("done_spurious", {63'd0, done}, 64'd0);
      end
      if (in_fifo_full && busy) check("full_blocks", {62'd0, s_ready, wr_fifo}, 64'd0);
      if (!busy) begin
        check("idle_ctl", {62'd0, s_ready, wr_fifo}, 64'd0);
        check("idle_din", din, 64'd0);
      end
      if (wr_fifo) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {63'd0, wr_fifo}, 64'd0);
        end else begin
          check("din", din, exp_q.pop_front());
          wr_seen++;
          if (len_q.size() > 0 && wr_seen == len_q[0]) begin
            void'(len_q.pop_front());
            wr_seen  = 0;
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_job(input int mm1, input int gap_pct, input int full_pct,
                         input bit directed, input bit poke_start, input int abort_after);
    int m;
    int beat;
    int writes;
    int cyc;
    bit fin;
    m      = mm1 + 1;
    beat   = 0;
    writes = 0;
    cyc    = 0;
    fin    = 1'b0;
    for (int k = 0; k < m; k++) begin
      if (directed) begin
        for (int i = 0; i < N; i++) begin
          beats[k][i*DW +: DW]     = 8'(8'h10 * k + i);
          beats[k][(N+i)*DW +: DW] = 8'(8'h80 + 8'h10 * k + i);
        end
      end else begin
        beats[k] = {$urandom, $urandom};
      end
    end
    for (int k = 0; k < m + N - 1; k++) exp_q.push_back(model_beat(k, m));
    len_q.push_back(m + N - 1);

    M_minus_one = 8'(mm1);
    start       = 1'b1;
    @(posedge sys_clk); #1;
    start       = 1'b0;
    M_minus_one = 8'($urandom);

    while (!fin && cyc < 3000) begin
      cyc++;
      if (beat < m) begin
        s_valid = ($urandom_range(0, 99) >= gap_pct);
        s_data  = beats[beat];
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = {$urandom, $urandom};
      end
      in_fifo_full = ($urandom_range(0, 99) < full_pct);
      if (poke_start && beat == 2) begin
        start       = 1'b1;
        M_minus_one = 8'd1;
      end
      @(negedge sys_clk); #1;
      if (s_valid && s_ready) beat++;
      if (wr_fifo) writes++;
      if (done) begin
        fin = 1'b1;
      end else if (abort_after > 0 && writes == abort_after) begin
        @(posedge sys_clk); #1;
        rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        wr_seen  = 0;
        exp_done = 1'b0;
        #1;
        check("rst_ctl", {60'd0, s_ready, wr_fifo, busy, done}, 64'd0);
        check("rst_din", din, 64'd0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge sys_clk); #1;
        start = 1'b0;
      end
    end
    start        = 1'b0;
    s_valid      = 1'b0;
    in_fifo_full = 1'b0;
    if (!fin) begin
      n_vec++;
      n_fail++;
      $display("FAIL job_timeout: m=%0d beats_accepted=%0d writes=%0d", m, beat, writes);
    end
    if (gap_pct == 0 && full_pct == 0 && abort_after == 0)
      check("job_cycles", 64'(cyc), 64'(m + N));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec        = 0;
    n_fail       = 0;
    wr_seen      = 0;
    exp_done     = 1'b0;
    rst          = 1'b1;
    start        = 1'b0;
    M_minus_one  = '0;
    s_valid      = 1'b0;
    s_data       = '0;
    in_fifo_full = 1'b0;
    #3;
    check("reset_ctl", {60'd0, s_ready, wr_fifo, busy, done}, 64'd0);
    check("reset_din", din, 64'd0);
    repeat (2) @(posedge sys_clk);
    #1 rst = 1'b0;
    s_data = {$urandom, $urandom};
    @(negedge sys_clk); #1;
    check("post_reset_din", din, 64'd0);
    @(posedge sys_clk); #1;

    run_job(3,   0,  0, 1'b1, 1'b0, 0);   // directed M=4, free-running
    run_job(3,   0, 30, 1'b1, 1'b0, 0);   // same stimulus with backpressure
    run_job(0,   0,  0, 1'b0, 1'b0, 0);   // M=1
    run_job(5,  20, 10, 0,    1'b1, 0);   // start pulsed mid-job is ignored
    run_job(7,   0,  0, 1'b0, 1'b0, 2);   // reset after two writes
    run_job(4,   0,  0, 1'b0, 1'b0, 0);   // fresh job right after reset
    run_job(255, 30, 10, 1'b0, 1'b0, 0);  // M=256 with gaps
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(0, 20)), 30, 20, 1'b0, 1'b0, 0);
    end

    repeat (4) @(posedge sys_clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("len_q_drained", 64'(len_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
